mrjong_rom_loader: RTL and testbench

Sits between the SPI `data_io` download stream and the Mr. Jong `core`, in the `clk_sys` domain. It decodes the ioctl byte stream into per-region ROM/PROM write strobes and registers them for one cycle. It counts and checksums the bytes received and validates the image length. It owns the core reset sequence: the core is held in reset until a valid image has loaded, and again for a fixed hold period after any soft reset.

---
 rtl/mrjong_pkg.sv | 42 ++++
 rtl/rom_region_decode.sv | 45 ++++
 rtl/mrjong_rom_loader.sv | 183 ++++++++++++++++++
 tb/tb_mrjong_rom_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrjong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mrjong_pkg                                                |
// | Brief    : Shared types and ROM image map for the Mr. Jong loader.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mrjong_pkg;

  // Loader sequencing states, with fixed encodings so they stay stable in dumps.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_t;

  // Image map: each region starts at its base and ends just below the next one.
  localparam logic [15:0] CPU_BASE = 16'h0000;
  localparam logic [15:0] GFX_BASE = 16'h8000;
  localparam logic [15:0] PAL_BASE = 16'hC000;
  localparam logic [15:0] LUT_BASE = 16'hC020;
  localparam logic [15:0] IMG_END  = 16'hC120;

  // Bit positions inside the region one-hot vector.
  localparam int unsigned REGION_W   = 4;
  localparam int unsigned REGION_CPU = 0;
  localparam int unsigned REGION_GFX = 1;
  localparam int unsigned REGION_PAL = 2;
  localparam int unsigned REGION_LUT = 3;

  // Offset of an image address from a region base, truncated to the ROM port width.
  function automatic logic [14:0] region_offset(input logic [15:0] addr,
                                                input logic [15:0] base);
    logic [15:0] diff;
    diff = addr - base;
    return diff[14:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rom_region_decode                                         |
// | Brief    : Maps an ioctl byte address onto a ROM/PROM region one-hot |
// |            and a region-relative address. Purely combinational.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rom_region_decode
  import mrjong_pkg::*;
(
  input  logic [24:0]         addr,
  output logic [REGION_W-1:0] region,
  output logic [14:0]         rel_addr
);

  logic [15:0] w_addr16;
  logic        w_in_image_page;

  // Only the first 64 KiB page can hold the image; anything above decodes to nothing.
  assign w_addr16        = addr[15:0];
  assign w_in_image_page = (addr[24:16] == 9'd0);

  // Pick the region by walking the bases in ascending order.
  always_comb begin
    region   = '0;
    rel_addr = '0;
    if (w_in_image_page) begin
      if (w_addr16 < GFX_BASE) begin
        region[REGION_CPU] = 1'b1;
        rel_addr           = region_offset(w_addr16, CPU_BASE);
      end else if (w_addr16 < PAL_BASE) begin
        region[REGION_GFX] = 1'b1;
        rel_addr           = {1'b0, w_addr16[13:0]};
      end else if (w_addr16 < LUT_BASE) begin
        region[REGION_PAL] = 1'b1;
        rel_addr           = region_offset(w_addr16, PAL_BASE);
      end else if (w_addr16 < IMG_END) begin
        region[REGION_LUT] = 1'b1;
        rel_addr           = region_offset(w_addr16, LUT_BASE);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mrjong_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mrjong_rom_loader                                         |
// | Brief    : Turns the data_io download stream into registered ROM     |
// |            region write strobes, counts/checksums the image, checks  |
// |            its length and sequences the core reset.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mrjong_rom_loader
  import mrjong_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX      = 8'd0,
  parameter logic [16:0] EXPECTED_BYTES = 17'h0C120,
  parameter int unsigned RESET_HOLD     = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        soft_reset,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        cpu_we,
  output logic        gfx_we,
  output logic        pal_we,
  output logic        lut_we,
  output logic        rom_loaded,
  output logic        load_error,
  output logic        core_reset,
  output logic [15:0] checksum
);

  localparam int unsigned         c_HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_HOLD - 1);

  loader_state_t       r_state;
  loader_state_t       w_state_nxt;
  logic                r_dl_q;
  logic                w_dl_rise;
  logic                w_dl_fall;
  logic                w_idx_match;
  logic                w_start;
  logic                w_accept;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [16:0]         r_byte_count;
  logic [15:0]         r_checksum;
  logic                r_rom_loaded;
  logic                r_load_error;
  logic                r_core_reset;
  logic [REGION_W-1:0] r_we;
  logic [14:0]         r_rom_addr;
  logic [7:0]          r_rom_data;
  logic [REGION_W-1:0] w_region;
  logic [14:0]         w_rel_addr;

  rom_region_decode u_decode (
    .addr     (ioctl_addr),
    .region   (w_region),
    .rel_addr (w_rel_addr)
  );

  // Download edges come from the previous-cycle copy of ioctl_download.
  assign w_dl_rise   = ioctl_download & ~r_dl_q;
  assign w_dl_fall   = ~ioctl_download & r_dl_q;
  assign w_idx_match = (ioctl_index == ROM_INDEX);

  // A new download of our image may restart the loader from any settled state.
  assign w_start  = w_dl_rise & w_idx_match &
                    (r_state != ST_LOAD) & (r_state != ST_CHECK);
  assign w_accept = ioctl_wr & w_idx_match & (r_state == ST_LOAD);

  // Next-state selection; a matching download start overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  w_state_nxt = ST_IDLE;
      ST_LOAD:  if (w_dl_fall) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = (r_byte_count == EXPECTED_BYTES) ? ST_HOLD : ST_ERROR;
      ST_HOLD:  if (!soft_reset && (r_hold_cnt == c_HOLD_LAST)) w_state_nxt = ST_RUN;
      ST_RUN:   if (soft_reset) w_state_nxt = ST_HOLD;
      ST_ERROR: w_state_nxt = ST_ERROR;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_start) begin
      w_state_nxt = ST_LOAD;
    end
  end

  // State register and the delayed download level used for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_dl_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dl_q  <= ioctl_download;
    end
  end

  // Hold timer: restarts on entry to HOLD and for as long as soft_reset is held.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= '0;
    end else if ((w_state_nxt == ST_HOLD) && ((r_state != ST_HOLD) || soft_reset)) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_HOLD) begin
      r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
    end
  end

  // Byte counter (saturating) and wrapping checksum over accepted bytes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_count <= '0;
      r_checksum   <= '0;
    end else if (w_start) begin
      r_byte_count <= '0;
      r_checksum   <= '0;
    end else if (w_accept) begin
      if (r_byte_count != '1) begin
        r_byte_count <= r_byte_count + 17'd1;
      end
      r_checksum <= r_checksum + {8'd0, ioctl_dout};
    end
  end

  // Image status flags, cleared when a new load starts and resolved in CHECK.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_loaded <= 1'b0;
      r_load_error <= 1'b0;
    end else if (w_start) begin
      r_rom_loaded <= 1'b0;
      r_load_error <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      if (w_state_nxt == ST_HOLD) begin
        r_rom_loaded <= 1'b1;
      end else begin
        r_load_error <= 1'b1;
      end
    end
  end

  // Core reset is registered from the next state so it drops on the cycle RUN begins.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_core_reset <= 1'b1;
    end else begin
      r_core_reset <= (w_state_nxt != ST_RUN);
    end
  end

  // One-cycle write strobes; address and data only move when a region is hit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_we       <= '0;
      r_rom_addr <= '0;
      r_rom_data <= '0;
    end else begin
      r_we <= w_accept ? w_region : '0;
      if (w_accept && (w_region != '0)) begin
        r_rom_addr <= w_rel_addr;
        r_rom_data <= ioctl_dout;
      end
    end
  end

  assign cpu_we     = r_we[REGION_CPU];
  assign gfx_we     = r_we[REGION_GFX];
  assign pal_we     = r_we[REGION_PAL];
  assign lut_we     = r_we[REGION_LUT];
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign rom_loaded = r_rom_loaded;
  assign load_error = r_load_error;
  assign core_reset = r_core_reset;
  assign checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_mrjong_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mrjong_rom_loader                                      |
// | Brief    : Self-checking bench for mrjong_rom_loader. A full-size    |
// |            instance takes one complete image; a short-image instance |
// |            exercises error, reload and reset-abort paths cheaply.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mrjong_rom_loader;

  localparam int c_IMG       = 'hC120;
  localparam int c_SMALL_LEN = 24;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        soft_reset;

  logic        cpu_we     [2];
  logic        gfx_we     [2];
  logic        pal_we     [2];
  logic        lut_we     [2];
  logic        rom_loaded [2];
  logic        load_error [2];
  logic        core_reset [2];
  logic [14:0] rom_addr   [2];
  logic [7:0]  rom_data   [2];
  logic [15:0] checksum   [2];

  int n_chk = 0;
  int n_err = 0;

  logic [24:0] q_addr[$];
  logic [7:0]  q_data[$];

  always #5 clk_sys = ~clk_sys;

  mrjong_rom_loader #(.ROM_INDEX(8'd0), .EXPECTED_BYTES(17'h0C120), .RESET_HOLD(16)) u_full (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .soft_reset(soft_reset),
    .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .cpu_we(cpu_we[0]), .gfx_we(gfx_we[0]),
    .pal_we(pal_we[0]), .lut_we(lut_we[0]), .rom_loaded(rom_loaded[0]),
    .load_error(load_error[0]), .core_reset(core_reset[0]), .checksum(checksum[0])
  );

  mrjong_rom_loader #(.ROM_INDEX(8'd0), .EXPECTED_BYTES(17'(c_SMALL_LEN)), .RESET_HOLD(16)) u_small (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .soft_reset(soft_reset),
    .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .cpu_we(cpu_we[1]), .gfx_we(gfx_we[1]),
    .pal_we(pal_we[1]), .lut_we(lut_we[1]), .rom_loaded(rom_loaded[1]),
    .load_error(load_error[1]), .core_reset(core_reset[1]), .checksum(checksum[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference image map: {cpu,gfx,pal,lut, relative address}, from plain address ranges.
  function automatic logic [18:0] ref_decode(input logic [24:0] a);
    int unsigned v;
    v = 32'(a);
    if (v < 'h8000) return {4'b1000, 15'(v)};
    if (v < 'hC000) return {4'b0100, 15'(v - 'h8000)};
    if (v < 'hC020) return {4'b0010, 15'(v - 'hC000)};
    if (v < 'hC120) return {4'b0001, 15'(v - 'hC020)};
    return 19'd0;
  endfunction

  function automatic logic [3:0] strobes(input int i);
    return {cpu_we[i], gfx_we[i], pal_we[i], lut_we[i]};
  endfunction

  task automatic check_reset_vals(input int i, input string tag);
    check({tag, "_we"},       strobes(i),    0);
    check({tag, "_addr"},     rom_addr[i],   0);
    check({tag, "_data"},     rom_data[i],   0);
    check({tag, "_loaded"},   rom_loaded[i], 0);
    check({tag, "_err"},      load_error[i], 0);
    check({tag, "_core_rst"}, core_reset[i], 1);
    check({tag, "_cksum"},    checksum[i],   0);
  endtask

  // Streams the queued bytes, two cycles per byte, checking every strobe on instance i.
  task automatic small_download(input int i, input logic [7:0] idx, input bit fall_with_last,
                                output logic [15:0] sum, output int fall_ago);
    int bad;
    int nb;
    logic [18:0] e;
    bad = 0;
    sum = 16'd0;
    nb  = q_addr.size();
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    if (idx == 8'd0) begin
      check("start_clr_loaded", rom_loaded[i], 0);
      check("start_clr_err",    load_error[i], 0);
      check("start_clr_cksum",  checksum[i],   0);
    end
    @(negedge clk_sys);
    for (int k = 0; k < nb; k++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = q_addr[k];
      ioctl_dout = q_data[k];
      if (fall_with_last && (k == nb - 1)) ioctl_download = 1'b0;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      e = (idx == 8'd0) ? ref_decode(q_addr[k]) : 19'd0;
      if (strobes(i) !== e[18:15]) bad++;
      else if ((e[18:15] != 4'd0) && ((rom_addr[i] !== e[14:0]) || (rom_data[i] !== q_data[k]))) bad++;
      sum = sum + 16'(q_data[k]);
      @(negedge clk_sys);
      if (strobes(i) !== 4'd0) bad++;
    end
    ioctl_download = 1'b0;
    fall_ago = fall_with_last ? 2 : 0;
    check("wr_path_bad", bad, 0);
  endtask

  // Core reset must still be high 17 cycles after the download fell and low at 18.
  task automatic check_release(input int i, input int fall_ago, input logic [15:0] sum,
                               input string tag);
    repeat (17 - fall_ago) @(negedge clk_sys);
    check({tag, "_cr_held"},  core_reset[i], 1);
    check({tag, "_loaded_h"}, rom_loaded[i], 1);
    @(negedge clk_sys);
    check({tag, "_cr_rel"},   core_reset[i], 0);
    check({tag, "_loaded"},   rom_loaded[i], 1);
    check({tag, "_err"},      load_error[i], 0);
    check({tag, "_cksum"},    checksum[i],   sum);
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      q_addr.push_back(25'($urandom_range(0, c_IMG - 1)));
      q_data.push_back(8'($urandom));
    end
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  logic [18:0] e_full;
  logic [15:0] full_sum;
  logic [15:0] s;
  int          fa;
  int          n_bad;
  int          n_cpu, n_gfx, n_pal, n_lut;
  int          hi;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timed out");
  end

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; soft_reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_reset_vals(0, "rst_full");
    check_reset_vals(1, "rst_small");
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Full image at one byte per cycle, data = addr[7:0].
    full_sum = 16'd0; n_bad = 0; n_cpu = 0; n_gfx = 0; n_pal = 0; n_lut = 0;
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int k = 0; k <= c_IMG; k++) begin
      if (k > 0) begin
        e_full = ref_decode(25'(k - 1));
        if ((strobes(0) !== e_full[18:15]) || (rom_addr[0] !== e_full[14:0]) ||
            (rom_data[0] !== 8'(k - 1))) n_bad++;
        n_cpu += int'(cpu_we[0]); n_gfx += int'(gfx_we[0]);
        n_pal += int'(pal_we[0]); n_lut += int'(lut_we[0]);
      end
      if (k < c_IMG) begin
        ioctl_wr = 1'b1; ioctl_addr = 25'(k); ioctl_dout = 8'(k);
        full_sum = full_sum + 16'(k % 256);
        @(negedge clk_sys);
      end
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    check("full_bad_bytes", n_bad, 0);
    check("full_cpu_cnt", n_cpu, 'h8000);
    check("full_gfx_cnt", n_gfx, 'h4000);
    check("full_pal_cnt", n_pal, 'h20);
    check("full_lut_cnt", n_lut, 'h100);
    check_release(0, 0, full_sum, "full");

    // One-cycle soft reset pulse in RUN.
    soft_reset = 1'b1;
    @(negedge clk_sys);
    soft_reset = 1'b0;
    hi = 0;
    for (int j = 0; j < 24; j++) begin
      if (core_reset[0] === 1'b1) hi++;
      @(negedge clk_sys);
    end
    check("soft_hold_len", hi, 16);
    check("soft_cr_after", core_reset[0], 0);
    check("soft_loaded", rom_loaded[0], 1);
    check("soft_cksum", checksum[0], full_sum);

    // Foreign index download mid-RUN is invisible to the loader.
    clear_q(); fill_random(8);
    small_download(0, 8'd1, 1'b0, s, fa);
    repeat (4) @(negedge clk_sys);
    ioctl_index = 8'd0;
    check("foreign_cr", core_reset[0], 0);
    check("foreign_loaded", rom_loaded[0], 1);
    check("foreign_cksum", checksum[0], full_sum);

    // Boundary addresses plus random fill; last byte shares the cycle with the fall.
    clear_q();
    q_addr = '{25'h0000, 25'h7FFF, 25'h8000, 25'hBFFF, 25'hC000, 25'hC01F, 25'hC020, 25'hC11F};
    for (int k = 0; k < 8; k++) q_data.push_back(8'($urandom));
    fill_random(c_SMALL_LEN - 8);
    small_download(1, 8'd0, 1'b1, s, fa);
    check_release(1, fa, s, "small1");

    // Reload over a resident image.
    clear_q(); fill_random(c_SMALL_LEN);
    small_download(1, 8'd0, 1'b0, s, fa);
    check_release(1, fa, s, "reload");

    // Short image ends in ERROR.
    clear_q(); fill_random(c_SMALL_LEN - 1);
    small_download(1, 8'd0, 1'b0, s, fa);
    repeat (30) @(negedge clk_sys);
    check("short_err", load_error[1], 1);
    check("short_loaded", rom_loaded[1], 0);
    check("short_cr", core_reset[1], 1);
    check("short_cksum", checksum[1], s);

    // Bytes past the image end and above the first page: counted, never strobed.
    clear_q(); fill_random(c_SMALL_LEN);
    q_addr.push_back(25'hC120);   q_data.push_back(8'($urandom));
    q_addr.push_back(25'h1_0005); q_data.push_back(8'($urandom));
    small_download(1, 8'd0, 1'b0, s, fa);
    repeat (30) @(negedge clk_sys);
    check("over_err", load_error[1], 1);
    check("over_cr", core_reset[1], 1);
    check("over_cksum", checksum[1], s);

    // reset_n asserted mid-load, in the same cycle as a byte strobe.
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int k = 0; k < 5; k++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'($urandom_range(0, c_IMG - 1)); ioctl_dout = 8'($urandom);
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b1; ioctl_addr = 25'h0100; ioctl_dout = 8'hA5; reset_n = 1'b0;
    @(negedge clk_sys);
    check_reset_vals(0, "abort_full");
    check_reset_vals(1, "abort_small");
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    clear_q(); fill_random(c_SMALL_LEN);
    small_download(1, 8'd0, 1'b0, s, fa);
    check_release(1, fa, s, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
